dac_spi_receiver: RTL and testbench
===================================

Name: dac_spi_receiver

Overview:
- Synthesizable receiving end of the serial DAC interface (CS_N / LDAC_N / DIN / SCLK) that the ASIC-function path drives.
- Oversamples the four serial lines with the system clock and deserializes MSB-first frames into an input register.
- Transfers the input register to a parallel DAC code on an LDAC_N falling edge, as a real DAC does.
- Used as an on-FPGA DAC emulator and loopback checker, so the reservoir ASIC path runs without the physical DAC.

Parameters:
- FRAME_BITS, 16, SCLK bits per CS_N frame.
- DATA_WIDTH, 16, DAC code width; must be ≤ FRAME_BITS; taken from the last DATA_WIDTH bits shifted in.
- SYNC_STAGES, 2, synchronizer flops per serial input; must be ≥ 2.

Ports:
- clk  input  1  system clock; must be ≥ 4× SCLK frequency
- rst  input  1  reset; rst asynchronous, active-high; clock clk
- dac_cs_n  input  1  frame select, active low
- dac_ldac_n  input  1  load DAC, falling edge active
- dac_din  input  1  serial data, sampled on SCLK rising edge
- dac_sclk  input  1  serial clock
- frame_data  output  DATA_WIDTH  input register (last good frame)
- frame_done  output  1  1-cycle pulse: good frame latched
- frame_err  output  1  1-cycle pulse: frame ended with wrong bit count
- dac_code  output  DATA_WIDTH  DAC register (current "analog" value)
- dac_update  output  1  1-cycle pulse: dac_code loaded
- busy  output  1  high while in SHIFT

Behaviour:
Reset values:
- All outputs 0.
- Synchronizers reset to idle levels: cs_n = 1, ldac_n = 1, sclk = 0, din = 0.
- bit_cnt = 0; shift register = 0; state = IDLE.

Synchronization and edge detection:
- Each input passes through SYNC_STAGES flops, then one history flop; edges are detected on synchronized values.
- Latency with SYNC_STAGES = 2: registered outputs update on the 3rd clk rising edge after the pin transition. The 1st edge is the one that first samples the new level.

FSM states: IDLE, SHIFT, LOADED.
- IDLE: synced cs_n falling → SHIFT; bit_cnt = 0.
- SHIFT (busy = 1):
  - Each synced sclk rising edge: shift_reg = {shift_reg, din_sync}.
  - bit_cnt increments, saturating at FRAME_BITS+1 (overrun marker).
  - sclk edges are ignored outside SHIFT.
- SHIFT, synced cs_n rising:
  - bit_cnt == FRAME_BITS: frame_data ← shift_reg[DATA_WIDTH-1:0]; frame_done pulses; → LOADED.
  - Any other count (short, overrun, or zero): frame_err pulses; frame_data unchanged; → IDLE.
- LOADED:
  - Synced ldac_n falling: dac_code ← frame_data; dac_update pulses; → IDLE.
  - Synced cs_n falling: → SHIFT (new frame; pending data stays in frame_data).

LDAC handling:
- An ldac_n falling edge in IDLE or SHIFT still loads dac_code from frame_data and pulses dac_update. This matches DAC behaviour; state is unchanged.

Simultaneous events:
- sclk rising and cs_n rising detected in the same cycle: the sclk edge is ignored and the count is evaluated without it.
- ldac_n falling in the same cycle as a good cs_n rising: dac_code takes the new frame value directly; state goes to IDLE.
- Glitch pulses shorter than 2 clk may be missed; there is no other filtering.

Reset mid-frame:
- Aborts the frame: no frame_err, returns to IDLE, clears all registers.
- The next frame is valid only if cs_n is seen high before its falling edge.

Optional Feature:
- Macro: DAC_RX_ERR_CNT_EN.
- Defined: adds output port err_count (8 bits, reset 0).
  - Increments on each frame_err and saturates at 255.
  - Cleared only by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- 16-bit frame 0xA5C3, SCLK = clk/8, then LDAC_N low pulse → frame_done once, frame_data = 0xA5C3; then dac_update once, dac_code = 0xA5C3.
- Frame 0x1234 with no LDAC, then frame 0xBEEF, then LDAC → dac_code stays 0 until LDAC, then becomes 0xBEEF; two frame_done pulses.
- 15-bit frame and 17-bit frame → frame_err each; frame_data keeps its prior value 0x00FF; with DAC_RX_ERR_CNT_EN, err_count = 2.
- LDAC_N falling aligned to the same synced cycle as CS_N rising of frame 0x0F0F → dac_code = 0x0F0F in that update; a single dac_update.
- rst asserted after 8 bits of frame 0xFFFF → all outputs 0, no frame_err; the next complete frame 0x0001 → frame_data = 0x0001.
- 300 consecutive 3-bit frames with DAC_RX_ERR_CNT_EN → err_count saturates at 255.

Source files
------------

// File: rtl/dac_spi_receiver.sv
// rtl/dac_spi_receiver.sv - serial DAC receiver/emulator: oversampled CS_N/LDAC_N/DIN/SCLK deserializer with DAC load
// Optional build macro: DAC_RX_ERR_CNT_EN adds an 8-bit saturating frame-error counter port (err_count).
module dac_spi_receiver #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dac_cs_n,
    input  logic                  dac_ldac_n,
    input  logic                  dac_din,
    input  logic                  dac_sclk,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [DATA_WIDTH-1:0] dac_code,
    output logic                  dac_update,
`ifdef DAC_RX_ERR_CNT_EN
    output logic [7:0]            err_count,
`endif
    output logic                  busy
);

    // Counter holds 0..FRAME_BITS+1; FRAME_BITS+1 marks an overrun and sticks there.
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_LOADED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_ldac_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic                   r_cs_hist;
    logic                   r_ldac_hist;
    logic                   r_sclk_hist;

    logic [CNT_W-1:0]       r_bit_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [DATA_WIDTH-1:0]  r_frame_data;
    logic [DATA_WIDTH-1:0]  r_dac_code;
    logic                   r_frame_done;
    logic                   r_frame_err;
    logic                   r_dac_update;
`ifdef DAC_RX_ERR_CNT_EN
    logic [7:0]             r_err_count;
`endif

    logic w_cs_s;
    logic w_ldac_s;
    logic w_din_s;
    logic w_sclk_s;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_ldac_fall;
    logic w_sclk_rise;
    logic w_busy;
    logic w_good_end;
    logic w_bad_end;
    logic w_shift_en;
    logic w_cnt_clr;

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_ldac_s = r_ldac_sync[SYNC_STAGES-1];
    assign w_din_s  = r_din_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];

    assign w_cs_fall   =  r_cs_hist   & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_hist   &  w_cs_s;
    assign w_ldac_fall =  r_ldac_hist & ~w_ldac_s;
    assign w_sclk_rise = ~r_sclk_hist &  w_sclk_s;

    // Synchronizer chains plus one history flop per line; reset to idle bus levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_ldac_sync <= '1;
            r_din_sync  <= '0;
            r_sclk_sync <= '0;
            r_cs_hist   <= 1'b1;
            r_ldac_hist <= 1'b1;
            r_sclk_hist <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   dac_cs_n};
            r_ldac_sync <= {r_ldac_sync[SYNC_STAGES-2:0], dac_ldac_n};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0],  dac_din};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], dac_sclk};
            r_cs_hist   <= w_cs_s;
            r_ldac_hist <= w_ldac_s;
            r_sclk_hist <= w_sclk_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a good frame end with a coincident LDAC goes straight to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_cs_rise) begin
                    if (r_bit_cnt == CNT_FULL && !w_ldac_fall) begin
                        w_next_state = S_LOADED;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_LOADED: begin
                if (w_cs_fall) begin
                    w_next_state = S_SHIFT;
                end else if (w_ldac_fall) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM output decode: busy flag and datapath strobes; a CS_N rise masks a same-cycle SCLK edge.
    always_comb begin
        w_busy     = (r_state == S_SHIFT);
        w_good_end = (r_state == S_SHIFT) && w_cs_rise && (r_bit_cnt == CNT_FULL);
        w_bad_end  = (r_state == S_SHIFT) && w_cs_rise && (r_bit_cnt != CNT_FULL);
        w_shift_en = (r_state == S_SHIFT) && w_sclk_rise && !w_cs_rise;
        w_cnt_clr  = (r_state != S_SHIFT) && w_cs_fall;
    end

    // Bit counter and shift register, active only while a frame is being shifted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_cnt_clr) begin
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_din_s};
            if (r_bit_cnt != CNT_OVER) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Input register and frame status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_data <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= w_good_end;
            r_frame_err  <= w_bad_end;
            if (w_good_end) begin
                r_frame_data <= r_shift[DATA_WIDTH-1:0];
            end
        end
    end

    // DAC register: loads on any LDAC_N fall, taking the just-completed frame if it ends this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dac_code   <= '0;
            r_dac_update <= 1'b0;
        end else begin
            r_dac_update <= w_ldac_fall;
            if (w_ldac_fall) begin
                r_dac_code <= w_good_end ? r_shift[DATA_WIDTH-1:0] : r_frame_data;
            end
        end
    end

`ifdef DAC_RX_ERR_CNT_EN
    // Saturating count of bad frames since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_bad_end && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign frame_data = r_frame_data;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign dac_code   = r_dac_code;
    assign dac_update = r_dac_update;
    assign busy       = w_busy;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// tb/tb_dac_spi_receiver.sv - randomized self-checking bench for dac_spi_receiver with a frame-level reference model
module tb_dac_spi_receiver;

    localparam int FB = 16;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          dac_cs_n;
    logic          dac_ldac_n;
    logic          dac_din;
    logic          dac_sclk;
    logic [DW-1:0] frame_data;
    logic          frame_done;
    logic          frame_err;
    logic [DW-1:0] dac_code;
    logic          dac_update;
    logic          busy;
`ifdef DAC_RX_ERR_CNT_EN
    logic [7:0]    err_count;
`endif

    int checks;
    int errors;

    // pulse counters observed on the outputs
    int n_done;
    int n_err;
    int n_upd;

    // reference model: frame-level rules only
    logic [DW-1:0] exp_fd;
    logic [DW-1:0] exp_dc;
    int            exp_errs;

    dac_spi_receiver #(
        .FRAME_BITS (FB),
        .DATA_WIDTH (DW),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dac_cs_n  (dac_cs_n),
        .dac_ldac_n(dac_ldac_n),
        .dac_din   (dac_din),
        .dac_sclk  (dac_sclk),
        .frame_data(frame_data),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .dac_code  (dac_code),
        .dac_update(dac_update),
`ifdef DAC_RX_ERR_CNT_EN
        .err_count (err_count),
`endif
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
        if (dac_update) n_upd++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        dac_cs_n   = 1'b1;
        dac_ldac_n = 1'b1;
        dac_din    = 1'b0;
        dac_sclk   = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        exp_fd   = '0;
        exp_dc   = '0;
        exp_errs = 0;
    endtask

    // MSB-first frame of nbits from value, SCLK = clk/8; optionally LDAC_N falls with CS_N rising
    task automatic send_frame(input logic [31:0] value, input int nbits, input bit ldac_with_cs);
        dac_cs_n = 1'b0;
        wait_clk(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            dac_din  = value[i];
            dac_sclk = 1'b0;
            wait_clk(4);
            dac_sclk = 1'b1;
            wait_clk(4);
        end
        dac_sclk = 1'b0;
        wait_clk(4);
        dac_cs_n = 1'b1;
        if (ldac_with_cs) dac_ldac_n = 1'b0;
        wait_clk(8);
        dac_ldac_n = 1'b1;
        wait_clk(4);
        if (nbits == FB) begin
            exp_fd = value[DW-1:0];
            if (ldac_with_cs) exp_dc = exp_fd;
        end else begin
            exp_errs++;
            if (ldac_with_cs) exp_dc = exp_fd;
        end
    endtask

    task automatic ldac_pulse();
        dac_ldac_n = 1'b0;
        wait_clk(4);
        dac_ldac_n = 1'b1;
        wait_clk(4);
        exp_dc = exp_fd;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (frame_data !== 16'h0) begin errors++; $display("FAIL reset_frame_data got %h exp 0000", frame_data); end
        checks++; if (dac_code !== 16'h0) begin errors++; $display("FAIL reset_dac_code got %h exp 0000", dac_code); end
        checks++; if ({frame_done, frame_err, dac_update, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {frame_done, frame_err, dac_update, busy}); end
`ifdef DAC_RX_ERR_CNT_EN
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
`endif
    endtask

    task automatic test_basic();
        int d0, u0;
        logic saw_busy;
        do_reset();
        d0 = n_done; u0 = n_upd;
        saw_busy = 1'b0;
        fork
            send_frame(32'hA5C3, 16, 1'b0);
            begin
                repeat (100) begin
                    @(negedge clk);
                    if (busy) saw_busy = 1'b1;
                end
            end
        join
        checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", saw_busy); end
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", n_done - d0); end
        checks++; if (frame_data !== exp_fd) begin errors++; $display("FAIL basic_frame_data got %h exp %h", frame_data, exp_fd); end
        checks++; if (dac_code !== 16'h0) begin errors++; $display("FAIL basic_dac_before_ldac got %h exp 0000", dac_code); end
        ldac_pulse();
        checks++; if (n_upd - u0 !== 1) begin errors++; $display("FAIL basic_update_count got %0d exp 1", n_upd - u0); end
        checks++; if (dac_code !== 16'hA5C3) begin errors++; $display("FAIL basic_dac_code got %h exp a5c3", dac_code); end
    endtask

    task automatic test_two_frames();
        int d0;
        do_reset();
        d0 = n_done;
        send_frame(32'h1234, 16, 1'b0);
        checks++; if (frame_data !== 16'h1234) begin errors++; $display("FAIL two_first_data got %h exp 1234", frame_data); end
        send_frame(32'hBEEF, 16, 1'b0);
        checks++; if (dac_code !== 16'h0) begin errors++; $display("FAIL two_dac_pre got %h exp 0000", dac_code); end
        checks++; if (n_done - d0 !== 2) begin errors++; $display("FAIL two_done_count got %0d exp 2", n_done - d0); end
        ldac_pulse();
        checks++; if (dac_code !== exp_dc) begin errors++; $display("FAIL two_dac_code got %h exp %h", dac_code, exp_dc); end
    endtask

    task automatic test_bad_count();
        int e0, d0;
        do_reset();
        send_frame(32'h00FF, 16, 1'b0);
        e0 = n_err; d0 = n_done;
        send_frame(32'h7FFF, 15, 1'b0);
        send_frame(32'h1AAAA, 17, 1'b0);
        checks++; if (n_err - e0 !== 2) begin errors++; $display("FAIL bad_err_count got %0d exp 2", n_err - e0); end
        checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL bad_done_count got %0d exp 0", n_done - d0); end
        checks++; if (frame_data !== 16'h00FF) begin errors++; $display("FAIL bad_frame_data got %h exp 00ff", frame_data); end
`ifdef DAC_RX_ERR_CNT_EN
        checks++; if (err_count !== 8'(exp_errs)) begin errors++; $display("FAIL bad_err_cnt_port got %0d exp %0d", err_count, exp_errs); end
`endif
    endtask

    task automatic test_ldac_simul();
        int u0;
        do_reset();
        send_frame(32'h5555, 16, 1'b0);
        u0 = n_upd;
        send_frame(32'h0F0F, 16, 1'b1);
        checks++; if (dac_code !== 16'h0F0F) begin errors++; $display("FAIL simul_dac_code got %h exp 0f0f", dac_code); end
        checks++; if (n_upd - u0 !== 1) begin errors++; $display("FAIL simul_update_count got %0d exp 1", n_upd - u0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int e0, d0;
        do_reset();
        send_frame(32'hCAFE, 16, 1'b0);
        ldac_pulse();
        e0 = n_err;
        dac_cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 8; i++) begin
            dac_din  = 1'b1;
            dac_sclk = 1'b0;
            wait_clk(4);
            dac_sclk = 1'b1;
            wait_clk(4);
        end
        rst = 1'b1;
        wait_clk(1);
        dac_cs_n = 1'b1;
        dac_sclk = 1'b0;
        dac_din  = 1'b0;
        wait_clk(4);
        checks++; if ({frame_data, dac_code} !== 32'h0) begin errors++; $display("FAIL midrst_regs got %h exp 0", {frame_data, dac_code}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        rst = 1'b0;
        wait_clk(10);
        exp_fd = '0; exp_dc = '0; exp_errs = 0;
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL midrst_no_err got %0d exp 0", n_err - e0); end
        d0 = n_done;
        send_frame(32'h0001, 16, 1'b0);
        checks++; if (frame_data !== 16'h0001) begin errors++; $display("FAIL midrst_next_frame got %h exp 0001", frame_data); end
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL midrst_done_count got %0d exp 1", n_done - d0); end
    endtask

    task automatic test_random();
        int d0, e0, u0, ed, ee, eu;
        logic [31:0] v;
        int len;
        bit do_ldac;
        bit simul;
        do_reset();
        d0 = n_done; e0 = n_err; u0 = n_upd;
        ed = 0; ee = 0; eu = 0;
        for (int k = 0; k < 40; k++) begin
            v = $urandom;
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : FB;
            simul = ($urandom_range(0, 5) == 0);
            do_ldac = ($urandom_range(0, 1) == 1);
            send_frame(v, len, simul);
            if (len == FB) ed++; else ee++;
            if (simul) eu++;
            if (do_ldac) begin
                ldac_pulse();
                eu++;
            end
            checks++; if (frame_data !== exp_fd) begin errors++; $display("FAIL rand_frame_data[%0d] got %h exp %h", k, frame_data, exp_fd); end
            checks++; if (dac_code !== exp_dc) begin errors++; $display("FAIL rand_dac_code[%0d] got %h exp %h", k, dac_code, exp_dc); end
        end
        checks++; if (n_done - d0 !== ed) begin errors++; $display("FAIL rand_done_count got %0d exp %0d", n_done - d0, ed); end
        checks++; if (n_err - e0 !== ee) begin errors++; $display("FAIL rand_err_count got %0d exp %0d", n_err - e0, ee); end
        checks++; if (n_upd - u0 !== eu) begin errors++; $display("FAIL rand_update_count got %0d exp %0d", n_upd - u0, eu); end
`ifdef DAC_RX_ERR_CNT_EN
        checks++; if (err_count !== 8'((exp_errs > 255) ? 255 : exp_errs)) begin errors++; $display("FAIL rand_err_cnt_port got %0d exp %0d", err_count, exp_errs); end
`endif
    endtask

    task automatic test_err_saturate();
        int e0;
        do_reset();
        e0 = n_err;
        for (int k = 0; k < 300; k++) begin
            send_frame($urandom, 3, 1'b0);
        end
        checks++; if (n_err - e0 !== 300) begin errors++; $display("FAIL sat_err_pulses got %0d exp 300", n_err - e0); end
        checks++; if (frame_data !== 16'h0) begin errors++; $display("FAIL sat_frame_data got %h exp 0000", frame_data); end
`ifdef DAC_RX_ERR_CNT_EN
        checks++; if (err_count !== 8'((exp_errs > 255) ? 255 : exp_errs)) begin errors++; $display("FAIL sat_err_cnt_port got %0d exp 255", err_count); end
`endif
    endtask

    initial begin
        checks = 0; errors = 0;
        n_done = 0; n_err = 0; n_upd = 0;
        exp_fd = '0; exp_dc = '0; exp_errs = 0;
        rst = 1'b1;
        dac_cs_n = 1'b1; dac_ldac_n = 1'b1; dac_din = 1'b0; dac_sclk = 1'b0;
        test_reset();
        test_basic();
        test_two_frames();
        test_bad_count();
        test_ldac_simul();
        test_reset_mid_frame();
        test_random();
        test_err_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
